// File: rtl/pc_gen.sv
// Program-counter generator: fetch sequencing, prioritised redirects and stale-response tracking.
// Optional build macro PC_GEN_MISALIGN_EN rejects misaligned jump targets and reports them.
module pc_gen #(
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] RESET_ADDR  = {ADDR_W{1'b0}},
    parameter int                STEP        = 4,
    parameter int                HOLD_W      = 3,
    parameter int                HOLD_PC_LVL = 1,
    parameter int                MAX_OUTST   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              jtag_reset_flag_i,
    input  logic              trap_flag_i,
    input  logic [ADDR_W-1:0] trap_addr_i,
    input  logic              jump_flag_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    input  logic [HOLD_W-1:0] hold_flag_i,
    output logic              req_valid_o,
    output logic [ADDR_W-1:0] req_addr_o,
    input  logic              req_ready_i,
    input  logic              rsp_valid_i,
    output logic              rsp_keep_o,
    output logic              flush_o,
`ifdef PC_GEN_MISALIGN_EN
    output logic              misalign_o,
    output logic [ADDR_W-1:0] misalign_addr_o,
`endif
    output logic [ADDR_W-1:0] pc_o
);

    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_STALL = 2'd2;
    localparam int         CNT_W    = $clog2(MAX_OUTST + 1);

    logic [1:0]        state_r;
    logic [1:0]        state_nxt_s;
    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] pc_nxt_s;
    logic [CNT_W-1:0]  outst_r;
    logic [CNT_W-1:0]  outst_nxt_s;
    logic [CNT_W-1:0]  stale_r;
    logic [CNT_W-1:0]  stale_nxt_s;
    logic              flush_r;
    logic              hold_s;
    logic              acc_s;
    logic              rsp_eff_s;
    logic              jump_take_s;
    logic              redirect_s;

`ifdef PC_GEN_MISALIGN_EN
    logic              misalign_r;
    logic [ADDR_W-1:0] misalign_addr_r;

    assign jump_take_s = jump_flag_i && (jump_addr_i[1:0] == 2'b00);

    // Report a misaligned jump only when it would have won arbitration.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            misalign_r      <= 1'b0;
            misalign_addr_r <= {ADDR_W{1'b0}};
        end else if (jump_flag_i && !jump_take_s && !jtag_reset_flag_i && !trap_flag_i) begin
            misalign_r      <= 1'b1;
            misalign_addr_r <= jump_addr_i;
        end else begin
            misalign_r      <= 1'b0;
            misalign_addr_r <= misalign_addr_r;
        end
    end

    assign misalign_o      = misalign_r;
    assign misalign_addr_o = misalign_addr_r;
`else
    assign jump_take_s = jump_flag_i;
`endif

    assign hold_s      = hold_flag_i > HOLD_W'(HOLD_PC_LVL);
    assign redirect_s  = jtag_reset_flag_i || trap_flag_i || jump_take_s;
    assign req_valid_o = (state_r == ST_RUN) && (outst_r != CNT_W'(MAX_OUTST));
    assign acc_s       = req_valid_o && req_ready_i;
    // A response with nothing outstanding is a protocol error; it is ignored so the count saturates.
    assign rsp_eff_s   = rsp_valid_i && (outst_r != {CNT_W{1'b0}});
    assign rsp_keep_o  = rsp_valid_i && (stale_r == {CNT_W{1'b0}});
    assign req_addr_o  = pc_r;
    assign pc_o        = pc_r;
    assign flush_o     = flush_r;

    // Next-state, PC and counter computation with redirect priority jtag > trap > jump.
    always_comb begin
        pc_nxt_s    = pc_r;
        state_nxt_s = state_r;
        outst_nxt_s = outst_r + CNT_W'(acc_s) - CNT_W'(rsp_eff_s);
        stale_nxt_s = stale_r;
        if (jtag_reset_flag_i) begin
            pc_nxt_s = RESET_ADDR;
        end else if (trap_flag_i) begin
            pc_nxt_s = trap_addr_i;
        end else if (jump_take_s) begin
            pc_nxt_s = jump_addr_i;
        end else if (acc_s) begin
            pc_nxt_s = pc_r + ADDR_W'(STEP);
        end else begin
            pc_nxt_s = pc_r;
        end
        if (redirect_s) begin
            stale_nxt_s = outst_nxt_s;
        end else if (rsp_eff_s && (stale_r != {CNT_W{1'b0}})) begin
            stale_nxt_s = stale_r - CNT_W'(1);
        end else begin
            stale_nxt_s = stale_r;
        end
        case (state_r)
            ST_BOOT:  state_nxt_s = ST_RUN;
            ST_RUN:   state_nxt_s = hold_s ? ST_STALL : ST_RUN;
            ST_STALL: state_nxt_s = hold_s ? ST_STALL : ST_RUN;
            default:  state_nxt_s = ST_BOOT;
        endcase
        if (redirect_s) begin
            state_nxt_s = hold_s ? ST_STALL : ST_RUN;
        end else begin
            state_nxt_s = state_nxt_s;
        end
    end

    // State, PC, counters and flush pulse registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_BOOT;
            pc_r    <= RESET_ADDR;
            outst_r <= {CNT_W{1'b0}};
            stale_r <= {CNT_W{1'b0}};
            flush_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            pc_r    <= pc_nxt_s;
            outst_r <= outst_nxt_s;
            stale_r <= stale_nxt_s;
            flush_r <= redirect_s;
        end
    end

    pc_gen_chk #(.CNT_W(CNT_W)) u_chk (
        .clk       (clk),
        .rst       (rst),
        .rsp_valid (rsp_valid_i),
        .outst_cnt (outst_r),
        .stale_cnt (stale_r)
    );

endmodule

// Protocol checks for pc_gen: no response without an outstanding fetch, stale never exceeds in-flight.
module pc_gen_chk #(
    parameter int CNT_W = 3
) (
    input logic             clk,
    input logic             rst,
    input logic             rsp_valid,
    input logic [CNT_W-1:0] outst_cnt,
    input logic [CNT_W-1:0] stale_cnt
);

    // Sampled every edge outside reset.
    always @(posedge clk) begin
        if (rst) begin
            assert (!(rsp_valid && (outst_cnt == {CNT_W{1'b0}})));
            assert (stale_cnt <= outst_cnt);
        end
    end

endmodule
